// File: rtl/clock_reset_gen_pkg.sv
// Shared types and constants for the 8085 clock/reset front end.
// Phase encoding, reset phase and stretch-counter sizing live here.
package intel8085_clk_pkg;

  typedef enum logic [1:0] {PH_T0, PH_T1, PH_T2, PH_T3} phase_t;

  // Reset parks the phase in T3 so the first released edge lands in T0.
  localparam phase_t PH_RESET = PH_T3;

  localparam int RST_HOLD_MAX = 15;
  localparam int RST_CNT_W    = 4;

  function automatic phase_t next_phase(input phase_t p);
    phase_t n;
    n = PH_T0;
    case (p)
      PH_T0:   n = PH_T1;
      PH_T1:   n = PH_T2;
      PH_T2:   n = PH_T3;
      default: n = PH_T0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/clock_reset_gen_rst_stretch.sv
// Reset stretcher: holds reset for RST_HOLD complete CLK periods after
// resetn_in is released, releasing only on an edge that produces T0.
module rst_stretch
  import intel8085_clk_pkg::*;
#(
  parameter int RST_HOLD = 3
) (
  input  logic x1,
  input  logic resetn_in,
  input  logic tick,
  output logic reset,
  output logic reset_out,
  output logic cycle_start
);

  localparam logic [RST_CNT_W-1:0] HOLD = RST_CNT_W'(RST_HOLD);

  logic [RST_CNT_W-1:0] rst_cnt;
  logic                 reset_next;

  // Once released, reset stays low until resetn_in drops again.
  // NOTE: every variable driven in always_comb gets a default first so no latch is inferred.
  always_comb begin
    reset_next = reset;
    if (tick && (rst_cnt == '0)) reset_next = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge x1) begin
    if (!resetn_in) begin
      rst_cnt     <= HOLD;
      reset       <= 1'b1;
      reset_out   <= 1'b1;
      cycle_start <= 1'b0;
    end else begin
      if (tick && (rst_cnt != '0)) rst_cnt <= rst_cnt - RST_CNT_W'(1);
      reset       <= reset_next;
      reset_out   <= reset_next;
      cycle_start <= tick && !reset_next;
    end
  end

endmodule

// File: rtl/clock_reset_gen.sv
// 8085 clock/reset front end: four-phase sequencer, registered phi1/phi2/CLK
// decode, phase-aligned READY sample and the stretched core reset.
module clock_reset_gen
  import intel8085_clk_pkg::*;
#(
  parameter int RST_HOLD = 3
) (
  input  logic x1,
  input  logic resetn_in,
  input  logic ready_in,
  output logic phi1,
  output logic phi2,
  output logic clk_out,
  output logic reset,
  output logic reset_out,
  output logic ready_sync,
  output logic cycle_start
);

  phase_t ph;
  phase_t ph_next;
  logic   tick;

  always_comb begin
    ph_next = PH_T0;
    ph_next = next_phase(ph);
  end

  assign tick = (ph_next == PH_T0);

  always_ff @(posedge x1) begin
    if (!resetn_in) ph <= PH_RESET;
    else            ph <= ph_next;
  end

  // Outputs are decoded from the next phase so they are registered yet in step with ph.
  always_ff @(posedge x1) begin
    if (!resetn_in) begin
      phi1       <= 1'b0;
      phi2       <= 1'b0;
      clk_out    <= 1'b0;
      ready_sync <= 1'b0;
    end else begin
      phi1    <= (ph_next == PH_T0);
      phi2    <= (ph_next == PH_T2);
      clk_out <= (ph_next == PH_T0) || (ph_next == PH_T1);
      if (ph_next == PH_T3) ready_sync <= ready_in;
    end
  end

  rst_stretch #(
    .RST_HOLD (RST_HOLD)
  ) u_rst_stretch (
    .x1          (x1),
    .resetn_in   (resetn_in),
    .tick        (tick),
    .reset       (reset),
    .reset_out   (reset_out),
    .cycle_start (cycle_start)
  );

endmodule
